// File: rtl/triangle_feeder.sv
// Host-side driver for the triangle engine: issues nt/xi/yi, queues po/xo/yo points.
// Optional watchdog on WAIT_BUSY enabled by defining TRI_FEEDER_TIMEOUT_EN.
module triangle_feeder #(
    parameter int FIFO_DEPTH  = 8,
    parameter int CNT_W       = 7,
    parameter int TIMEOUT_CYC = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tri_valid,
    output logic             tri_ready,
    input  logic [17:0]      tri_v,
    output logic             nt,
    output logic [2:0]       xi,
    output logic [2:0]       yi,
    input  logic             busy,
    input  logic             po,
    input  logic [2:0]       xo,
    input  logic [2:0]       yo,
    output logic             pt_valid,
    input  logic             pt_ready,
    output logic [5:0]       pt_data,
    output logic             tri_done,
    output logic [CNT_W-1:0] tri_pts,
    output logic             ovf
`ifdef TRI_FEEDER_TIMEOUT_EN
    ,
    output logic             timeout
`endif
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_V1   = 3'd1;
    localparam logic [2:0] S_V2   = 3'd2;
    localparam logic [2:0] S_V3   = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4;
    localparam logic [2:0] S_RUN  = 3'd5;

    logic [2:0]       state_q, state_d;
    logic             nt_q, nt_d;
    logic [2:0]       xi_q, xi_d, yi_q, yi_d;
    logic [11:0]      tri_q, tri_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [CNT_W-1:0] pts_q, pts_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      occ_q, occ_d;
    logic [5:0]       mem_q [FIFO_DEPTH];
    logic             accept, full, pop, push;

`ifdef TRI_FEEDER_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    logic [WD_W-1:0] wd_q, wd_d;
    logic            to_q, to_d;
    assign timeout = to_q;
`else
    logic [31:0] unused_timeout_cyc;
    assign unused_timeout_cyc = TIMEOUT_CYC;
`endif

    assign tri_ready = (state_q == S_IDLE) && !busy;
    assign accept    = tri_valid && tri_ready;
    assign full      = (occ_q == (AW+1)'(FIFO_DEPTH));
    assign pt_valid  = (occ_q != '0);
    assign pop       = pt_valid && pt_ready;
    // A pop frees the slot in the same cycle, so a push at full still lands.
    assign push      = po && (!full || pop);
    assign pt_data   = mem_q[rd_q];
    assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    assign nt       = nt_q;
    assign xi       = xi_q;
    assign yi       = yi_q;
    assign tri_done = done_q;
    assign tri_pts  = pts_q;
    assign ovf      = ovf_q;

    always_comb begin
        state_d = state_q;
        tri_d   = tri_q;
        cnt_d   = cnt_q;
        pts_d   = pts_q;
        done_d  = 1'b0;
`ifdef TRI_FEEDER_TIMEOUT_EN
        wd_d    = '0;
        to_d    = to_q;
`endif
        if (state_q != S_IDLE && po) begin
            cnt_d = cnt_inc;
        end
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    tri_d   = tri_v[11:0];
                    cnt_d   = '0;
                    state_d = S_V1;
                end
            end
            S_V1: state_d = S_V2;
            S_V2: state_d = S_V3;
            S_V3: state_d = S_WAIT;
            S_WAIT: begin
                if (busy) begin
                    state_d = S_RUN;
`ifdef TRI_FEEDER_TIMEOUT_EN
                end else if (wd_q == WD_W'(TIMEOUT_CYC - 1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    pts_d   = '0;
                    to_d    = 1'b1;
                end else begin
                    wd_d = wd_q + 1'b1;
`endif
                end
            end
            S_RUN: begin
                if (!busy) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    pts_d   = cnt_d;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Engine-facing outputs are decoded from the next state so they register cleanly.
    always_comb begin
        nt_d = 1'b0;
        xi_d = 3'd0;
        yi_d = 3'd0;
        unique case (state_d)
            S_V1: begin
                nt_d = 1'b1;
                xi_d = tri_v[17:15];
                yi_d = tri_v[14:12];
            end
            S_V2: begin
                xi_d = tri_q[11:9];
                yi_d = tri_q[8:6];
            end
            S_V3: begin
                xi_d = tri_q[5:3];
                yi_d = tri_q[2:0];
            end
            default: ;
        endcase
    end

    always_comb begin
        wr_d  = push ? wr_q + 1'b1 : wr_q;
        rd_d  = pop ? rd_q + 1'b1 : rd_q;
        occ_d = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (pop && !push) begin
            occ_d = occ_q - 1'b1;
        end
        ovf_d = ovf_q | (po && !push);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            nt_q    <= 1'b0;
            xi_q    <= 3'd0;
            yi_q    <= 3'd0;
            tri_q   <= '0;
            cnt_q   <= '0;
            pts_q   <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            occ_q   <= '0;
`ifdef TRI_FEEDER_TIMEOUT_EN
            wd_q    <= '0;
            to_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            nt_q    <= nt_d;
            xi_q    <= xi_d;
            yi_q    <= yi_d;
            tri_q   <= tri_d;
            cnt_q   <= cnt_d;
            pts_q   <= pts_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            occ_q   <= occ_d;
`ifdef TRI_FEEDER_TIMEOUT_EN
            wd_q    <= wd_d;
            to_q    <= to_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_q] <= {xo, yo};
        end
    end

endmodule

// File: tb/tb_triangle_feeder.sv
// Directed self-checking bench for triangle_feeder.
// Drives a scripted engine model; optional watchdog test under TRI_FEEDER_TIMEOUT_EN.
module tb_triangle_feeder;

    logic        clk = 1'b0;
    logic        reset, tri_valid, tri_ready, busy, po, pt_valid, pt_ready;
    logic [17:0] tri_v;
    logic        nt, tri_done, ovf;
    logic [2:0]  xi, yi, xo, yo;
    logic [5:0]  pt_data;
    logic [6:0]  tri_pts;
`ifdef TRI_FEEDER_TIMEOUT_EN
    logic        timeout;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int done_cnt = 0;
    logic [6:0] last_pts = '0;
    logic [5:0] popped[$];
    logic [6:0] issued[$];
    int         issued_cyc[$];

    triangle_feeder #(.FIFO_DEPTH(8), .CNT_W(7), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .reset(reset),
        .tri_valid(tri_valid), .tri_ready(tri_ready), .tri_v(tri_v),
        .nt(nt), .xi(xi), .yi(yi),
        .busy(busy), .po(po), .xo(xo), .yo(yo),
        .pt_valid(pt_valid), .pt_ready(pt_ready), .pt_data(pt_data),
        .tri_done(tri_done), .tri_pts(tri_pts), .ovf(ovf)
`ifdef TRI_FEEDER_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs only change at posedge+1, so negedge sees what the next edge will see.
    always @(negedge clk) begin
        if (pt_valid && pt_ready) popped.push_back(pt_data);
        if (nt || xi != 3'd0 || yi != 3'd0) begin
            issued.push_back({nt, xi, yi});
            issued_cyc.push_back(cyc);
        end
        if (tri_done) begin
            done_cnt++;
            last_pts = tri_pts;
        end
    end

    function automatic logic [5:0] pt(int i);
        logic [2:0] a, b;
        a = 3'(i);
        b = 3'(i * 3);
        return {a, b};
    endfunction

    task automatic step(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset;
        reset = 1'b1; tri_valid = 1'b0; tri_v = '0; busy = 1'b0;
        po = 1'b0; xo = '0; yo = '0; pt_ready = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic emit(int base, int n);
        logic [5:0] p;
        for (int k = 0; k < n; k++) begin
            p = pt(base + k);
            po = 1'b1; xo = p[5:3]; yo = p[2:0];
            step(1);
        end
        po = 1'b0;
    endtask

    task automatic issue_tri(logic [17:0] v);
        tri_v = v;
        tri_valid = 1'b1;
        #0;
        for (int k = 0; k < 50 && !tri_ready; k++) step(1);
        checks++;
        if (tri_ready !== 1'b1) begin
            failures++;
            $display("FAIL issue_ready got=%b exp=1", tri_ready);
        end
        step(1);
        tri_valid = 1'b0;
    endtask

    task automatic drain(output int n);
        n = 0;
        pt_ready = 1'b1;
        for (int k = 0; k < 20 && pt_valid; k++) begin
            step(1);
            n++;
        end
        pt_ready = 1'b0;
        step(1);
    endtask

    task automatic test_reset;
        do_reset();
        checks++; if (tri_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", tri_ready); end
        checks++; if (nt !== 1'b0) begin failures++; $display("FAIL rst_nt got=%b exp=0", nt); end
        checks++; if ({xi, yi} !== 6'd0) begin failures++; $display("FAIL rst_xy got=%h exp=0", {xi, yi}); end
        checks++; if (pt_valid !== 1'b0) begin failures++; $display("FAIL rst_pt_valid got=%b exp=0", pt_valid); end
        checks++; if (tri_done !== 1'b0) begin failures++; $display("FAIL rst_done got=%b exp=0", tri_done); end
        checks++; if (tri_pts !== 7'd0) begin failures++; $display("FAIL rst_pts got=%0d exp=0", tri_pts); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%b exp=0", ovf); end
`ifdef TRI_FEEDER_TIMEOUT_EN
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL rst_timeout got=%b exp=0", timeout); end
`endif
    endtask

    task automatic test_basic_issue;
        int bi, bp, bd;
        logic [6:0] exp_iss [3];
        exp_iss[0] = {1'b1, 3'd1, 3'd1};
        exp_iss[1] = {1'b0, 3'd1, 3'd5};
        exp_iss[2] = {1'b0, 3'd5, 3'd5};
        bi = issued.size(); bp = popped.size(); bd = done_cnt;
        pt_ready = 1'b1;
        issue_tri({3'd1, 3'd1, 3'd1, 3'd5, 3'd5, 3'd5});
        checks++;
        if ({nt, xi, yi} !== exp_iss[0]) begin
            failures++;
            $display("FAIL basic_v1 got=%h exp=%h", {nt, xi, yi}, exp_iss[0]);
        end
        step(4);
        busy = 1'b1;
        emit(0, 15);
        busy = 1'b0;
        step(3);
        checks++;
        if (issued.size() - bi != 3) begin
            failures++;
            $display("FAIL basic_issue_cnt got=%0d exp=3", issued.size() - bi);
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (issued[bi+k] !== exp_iss[k]) begin
                    failures++;
                    $display("FAIL basic_vertex%0d got=%h exp=%h", k, issued[bi+k], exp_iss[k]);
                end
            end
            checks++;
            if (issued_cyc[bi+2] - issued_cyc[bi] != 2) begin
                failures++;
                $display("FAIL basic_consecutive got=%0d exp=2", issued_cyc[bi+2] - issued_cyc[bi]);
            end
        end
        checks++;
        if (popped.size() - bp != 15) begin
            failures++;
            $display("FAIL basic_pop_cnt got=%0d exp=15", popped.size() - bp);
        end else begin
            for (int k = 0; k < 15; k++) begin
                checks++;
                if (popped[bp+k] !== pt(k)) begin
                    failures++;
                    $display("FAIL basic_pt%0d got=%h exp=%h", k, popped[bp+k], pt(k));
                end
            end
        end
        checks++; if (done_cnt - bd != 1) begin failures++; $display("FAIL basic_done got=%0d exp=1", done_cnt - bd); end
        checks++; if (last_pts !== 7'd15) begin failures++; $display("FAIL basic_pts got=%0d exp=15", last_pts); end
        pt_ready = 1'b0;
    endtask

    task automatic test_busy_gating;
        int bi, bd;
        bi = issued.size(); bd = done_cnt;
        busy = 1'b1;
        tri_v = {3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        tri_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(1);
            checks++;
            if (tri_ready !== 1'b0) begin
                failures++;
                $display("FAIL gate_ready%0d got=%b exp=0", k, tri_ready);
            end
        end
        checks++;
        if (issued.size() != bi) begin
            failures++;
            $display("FAIL gate_no_nt got=%0d exp=0", issued.size() - bi);
        end
        busy = 1'b0;
        #1;
        checks++; if (tri_ready !== 1'b1) begin failures++; $display("FAIL gate_release got=%b exp=1", tri_ready); end
        step(1);
        tri_valid = 1'b0;
        checks++;
        if ({nt, xi, yi} !== {1'b1, 3'd2, 3'd3}) begin
            failures++;
            $display("FAIL gate_v1 got=%h exp=%h", {nt, xi, yi}, {1'b1, 3'd2, 3'd3});
        end
        step(3);
        busy = 1'b1;
        step(1);
        busy = 1'b0;
        step(2);
        checks++; if (done_cnt - bd != 1) begin failures++; $display("FAIL gate_done got=%0d exp=1", done_cnt - bd); end
        checks++; if (last_pts !== 7'd0) begin failures++; $display("FAIL gate_pts got=%0d exp=0", last_pts); end
    endtask

    task automatic test_overflow;
        int bp, n;
        do_reset();
        issue_tri({3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5});
        step(3);
        busy = 1'b1;
        emit(20, 10);
        busy = 1'b0;
        step(3);
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", ovf); end
        checks++; if (last_pts !== 7'd10) begin failures++; $display("FAIL ovf_pts got=%0d exp=10", last_pts); end
        bp = popped.size();
        drain(n);
        checks++; if (n != 8) begin failures++; $display("FAIL ovf_pops got=%0d exp=8", n); end
        checks++; if (pt_valid !== 1'b0) begin failures++; $display("FAIL ovf_empty got=%b exp=0", pt_valid); end
        checks++;
        if (popped.size() - bp != 8) begin
            failures++;
            $display("FAIL ovf_pop_cnt got=%0d exp=8", popped.size() - bp);
        end else begin
            for (int k = 0; k < 8; k++) begin
                checks++;
                if (popped[bp+k] !== pt(20 + k)) begin
                    failures++;
                    $display("FAIL ovf_pt%0d got=%h exp=%h", k, popped[bp+k], pt(20 + k));
                end
            end
        end
    endtask

    task automatic test_full_push_pop;
        int bp, bd, n;
        logic [5:0] p;
        do_reset();
        bd = done_cnt;
        emit(40, 8);
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL fpp_fill_ovf got=%b exp=0", ovf); end
        checks++; if (done_cnt != bd) begin failures++; $display("FAIL fpp_idle_done got=%0d exp=0", done_cnt - bd); end
        bp = popped.size();
        p = pt(48);
        pt_ready = 1'b1; po = 1'b1; xo = p[5:3]; yo = p[2:0];
        step(1);
        pt_ready = 1'b0; po = 1'b0;
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL fpp_ovf got=%b exp=0", ovf); end
        // One further push must be dropped if occupancy really stayed at 8.
        emit(49, 1);
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL fpp_still_full got=%b exp=1", ovf); end
        drain(n);
        checks++;
        if (popped.size() - bp != 9) begin
            failures++;
            $display("FAIL fpp_pop_cnt got=%0d exp=9", popped.size() - bp);
        end else begin
            for (int k = 0; k < 9; k++) begin
                checks++;
                if (popped[bp+k] !== pt(40 + k)) begin
                    failures++;
                    $display("FAIL fpp_pt%0d got=%h exp=%h", k, popped[bp+k], pt(40 + k));
                end
            end
        end
    endtask

    task automatic test_reset_mid_op;
        int bi, bd;
        do_reset();
        emit(60, 9);
        pt_ready = 1'b1;
        step(5);
        pt_ready = 1'b0;
        checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL mid_pre_ovf got=%b exp=1", ovf); end
        checks++; if (pt_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got=%b exp=1", pt_valid); end
        issue_tri({3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6});
        step(1);
        checks++;
        if ({nt, xi, yi} !== {1'b0, 3'd3, 3'd4}) begin
            failures++;
            $display("FAIL mid_v2 got=%h exp=%h", {nt, xi, yi}, {1'b0, 3'd3, 3'd4});
        end
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        checks++; if (tri_ready !== 1'b1) begin failures++; $display("FAIL mid_idle got=%b exp=1", tri_ready); end
        checks++; if ({nt, xi, yi} !== 7'd0) begin failures++; $display("FAIL mid_outs got=%h exp=0", {nt, xi, yi}); end
        checks++; if (pt_valid !== 1'b0) begin failures++; $display("FAIL mid_flush got=%b exp=0", pt_valid); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL mid_ovf got=%b exp=0", ovf); end
        bi = issued.size(); bd = done_cnt;
        step(4);
        checks++; if (issued.size() != bi) begin failures++; $display("FAIL mid_no_issue got=%0d exp=0", issued.size() - bi); end
        checks++; if (done_cnt != bd) begin failures++; $display("FAIL mid_no_done got=%0d exp=0", done_cnt - bd); end
    endtask

    task automatic test_saturation;
        do_reset();
        pt_ready = 1'b1;
        issue_tri({3'd1, 3'd1, 3'd2, 3'd2, 3'd3, 3'd3});
        step(3);
        busy = 1'b1;
        emit(0, 130);
        busy = 1'b0;
        step(3);
        pt_ready = 1'b0;
        checks++; if (last_pts !== 7'd127) begin failures++; $display("FAIL sat_pts got=%0d exp=127", last_pts); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL sat_ovf got=%b exp=0", ovf); end
    endtask

`ifdef TRI_FEEDER_TIMEOUT_EN
    task automatic test_timeout;
        do_reset();
        issue_tri({3'd1, 3'd2, 3'd1, 3'd2, 3'd1, 3'd2});
        step(3);
        emit(70, 2);
        step(13);
        checks++; if (tri_done !== 1'b0) begin failures++; $display("FAIL to_early_done got=%b exp=0", tri_done); end
        checks++; if (timeout !== 1'b0) begin failures++; $display("FAIL to_early_flag got=%b exp=0", timeout); end
        step(1);
        checks++; if (tri_done !== 1'b1) begin failures++; $display("FAIL to_done got=%b exp=1", tri_done); end
        checks++; if (tri_pts !== 7'd0) begin failures++; $display("FAIL to_pts got=%0d exp=0", tri_pts); end
        checks++; if (timeout !== 1'b1) begin failures++; $display("FAIL to_flag got=%b exp=1", timeout); end
        checks++; if (tri_ready !== 1'b1) begin failures++; $display("FAIL to_ready got=%b exp=1", tri_ready); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_issue();
        test_busy_gating();
        test_overflow();
        test_full_push_pop();
        test_reset_mid_op();
        test_saturation();
`ifdef TRI_FEEDER_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
